// File: rtl/path_seq_pkg.sv
// Shared types and constants for the path sequencer: state encoding, sizing and the "no node" marker.
package path_seq_pkg;

  localparam int unsigned NODE_W = 5;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [NODE_W-1:0] NODE_NONE = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/path_node_ram.sv
// Path node buffer: DEPTH x NODE_W register array, one synchronous write port, one asynchronous read port.
module path_node_ram
  import path_seq_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NODE_W-1:0] rdata_c
);

  logic [NODE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/path_sequencer.sv
// Captures a streamed Dijkstra node sequence, then steps through it one node per arrival pulse,
// presenting the next target node and flagging completion or off-path errors.
module path_sequencer
  import path_seq_pkg::*;
(
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              path_clear,
  input  logic              node_in_valid,
  input  logic [NODE_W-1:0] node_in,
  input  logic              path_end,
  input  logic              node_changed,
  input  logic [NODE_W-1:0] realtime_pos,
  output logic [NODE_W-1:0] next_node,
  output logic              next_valid,
  output logic              path_active,
  output logic              path_done,
  output logic              path_error,
  output logic [CNT_W-1:0]  node_count
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  load_cnt;
  logic [NODE_W-1:0] next_node_d;
  logic              next_valid_d, active_d, done_d, error_d;

  logic              we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [NODE_W-1:0] rdata_c, rd_node;

  path_node_ram u_ram (
    .clk     (clk_50M),
    .we      (we),
    .waddr   (waddr),
    .wdata   (node_in),
    .raddr   (raddr),
    .rdata_c (rdata_c)
  );

  // Entering RUN reads slot 1; stepping reads the slot after the current pointer.
  assign raddr   = (state_q == S_LOAD) ? ADDR_W'(1) : ADDR_W'(rd_ptr_q + CNT_W'(1));
  // Forward a same-cycle write so the last loaded node can be presented immediately.
  assign rd_node = (we && (waddr == raddr)) ? node_in : rdata_c;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      next_node   <= '0;
      next_valid  <= 1'b0;
      path_active <= 1'b0;
      path_done   <= 1'b0;
      path_error  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      next_node   <= next_node_d;
      next_valid  <= next_valid_d;
      path_active <= active_d;
      path_done   <= done_d;
      path_error  <= error_d;
    end
  end

  assign node_count = count_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    next_node_d  = next_node;
    next_valid_d = next_valid;
    done_d       = 1'b0;
    error_d      = path_error;
    we           = 1'b0;
    waddr        = '0;
    load_cnt     = count_q;

    if (path_clear) begin
      state_d      = S_IDLE;
      count_d      = '0;
      rd_ptr_d     = '0;
      next_valid_d = 1'b0;
      next_node_d  = NODE_NONE;
      error_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (node_in_valid) begin
            we           = 1'b1;
            waddr        = '0;
            count_d      = CNT_W'(1);
            rd_ptr_d     = '0;
            next_valid_d = 1'b0;
            next_node_d  = NODE_NONE;
            state_d      = S_LOAD;
          end else if (path_end && state_q == S_IDLE) begin
            error_d      = 1'b1;
            next_valid_d = 1'b0;
            next_node_d  = NODE_NONE;
            state_d      = S_ERROR;
          end
        end

        S_LOAD: begin
          if (node_in_valid) begin
            if (count_q == CNT_W'(DEPTH)) begin
              error_d      = 1'b1;
              next_valid_d = 1'b0;
              next_node_d  = NODE_NONE;
              state_d      = S_ERROR;
            end else begin
              we       = 1'b1;
              waddr    = ADDR_W'(count_q);
              load_cnt = count_q + CNT_W'(1);
              count_d  = load_cnt;
            end
          end
          // path_end sees the count including any write made this cycle.
          if (path_end && state_d == S_LOAD) begin
            if (load_cnt == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              rd_ptr_d     = CNT_W'(1);
              next_node_d  = rd_node;
              next_valid_d = 1'b1;
              state_d      = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (node_changed) begin
            if (realtime_pos == next_node) begin
              rd_ptr_d = rd_ptr_q + CNT_W'(1);
              if (rd_ptr_d == count_q) begin
                done_d       = 1'b1;
                next_valid_d = 1'b0;
                next_node_d  = NODE_NONE;
                state_d      = S_DONE;
              end else begin
                next_node_d = rd_node;
              end
            end else begin
              error_d      = 1'b1;
              next_valid_d = 1'b0;
              next_node_d  = NODE_NONE;
              state_d      = S_ERROR;
            end
          end
        end

        S_ERROR: begin
          error_d      = 1'b1;
          next_valid_d = 1'b0;
          next_node_d  = NODE_NONE;
        end

        default: state_d = S_IDLE;
      endcase
    end

    active_d = (state_d == S_LOAD) || (state_d == S_RUN);
  end

endmodule
